reg_file_mport: RTL and testbench

Parametrised multi-read-port register file, the successor to the two-port combinational/clocked register files in the MEM area. It has NUM_RD registered read ports and one byte-masked write port, with write-to-read bypass and an optional hardwired zero register. A built-in clear sequencer zeroes the whole array one entry per cycle, after reset or on request, instead of a reset loop over the array. It sits between decode and execute in the training datapath.

---
 rtl/reg_file_mport.sv | 147 ++++++++++++++
 tb/tb_reg_file_mport.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mport.sv
// Multi-read-port register file: NUM_RD registered read ports, one byte-masked
// write port with same-cycle bypass, and a sequential clear engine.

module reg_file_mport_rd #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 5,
    parameter int ZERO_REG  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req,
    input  logic [ADDR_SIZE-1:0] i_addr,
    input  logic [WORD_SIZE-1:0] i_mem_word,
    input  logic                 i_wr_hit,
    input  logic [ADDR_SIZE-1:0] i_wr_addr,
    input  logic [WORD_SIZE-1:0] i_wr_word,
    output logic [WORD_SIZE-1:0] o_data,
    output logic                 o_valid
);
    logic [WORD_SIZE-1:0] word;

    // Zero register beats bypass; bypass beats the stored value.
    always_comb begin
        word = i_mem_word;
        if (ZERO_REG != 0 && i_addr == '0)
            word = '0;
        else if (i_wr_hit && i_wr_addr == i_addr)
            word = i_wr_word;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= i_req;
            if (i_req)
                o_data <= word;
        end
    end
endmodule

module reg_file_mport #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 5,
    parameter int NUM_RD    = 2,
    parameter int ZERO_REG  = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_RD-1:0]           i_rd_en,
    input  logic [NUM_RD*ADDR_SIZE-1:0] i_rd_addr,
    output logic [NUM_RD*WORD_SIZE-1:0] o_rd_data,
    output logic [NUM_RD-1:0]           o_rd_valid,
    input  logic                        i_wr_en,
    input  logic [ADDR_SIZE-1:0]        i_wr_addr,
    input  logic [WORD_SIZE-1:0]        i_wr_data,
    input  logic [WORD_SIZE/8-1:0]      i_wr_be,
    input  logic                        i_clr,
    output logic                        o_busy
);
    localparam int DEPTH     = 2**ADDR_SIZE;
    localparam int NUM_BYTES = WORD_SIZE/8;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t                           state_q, state_d;
    logic [ADDR_SIZE-1:0]             clr_idx_q, clr_idx_d;
    logic [WORD_SIZE-1:0]             mem [DEPTH];
    logic                             idle_go, wr_accept;
    logic [WORD_SIZE-1:0]             wr_old, wr_merged;
    logic [NUM_RD-1:0][ADDR_SIZE-1:0] rd_addr;
    logic [NUM_RD-1:0][WORD_SIZE-1:0] rd_data;

    // A clear request in IDLE swallows any same-cycle read or write.
    assign idle_go   = (state_q == IDLE) && !i_clr;
    assign wr_accept = idle_go && i_wr_en && !(ZERO_REG != 0 && i_wr_addr == '0);
    assign wr_old    = mem[i_wr_addr];

    always_comb begin
        wr_merged = wr_old;
        for (int b = 0; b < NUM_BYTES; b++)
            if (i_wr_be[b])
                wr_merged[b*8 +: 8] = i_wr_data[b*8 +: 8];
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + ADDR_SIZE'(1);
                if (clr_idx_q == {ADDR_SIZE{1'b1}})
                    state_d = IDLE;
            end
            IDLE: begin
                if (i_clr) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Array has no reset; the clear engine zeroes it one entry per cycle.
    always_ff @(posedge i_clk) begin
        if (state_q == CLEAR)
            mem[clr_idx_q] <= '0;
        else if (wr_accept)
            mem[i_wr_addr] <= wr_merged;
    end

    assign rd_addr = i_rd_addr;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        reg_file_mport_rd #(
            .WORD_SIZE (WORD_SIZE),
            .ADDR_SIZE (ADDR_SIZE),
            .ZERO_REG  (ZERO_REG)
        ) u_rd (
            .i_clk      (i_clk),
            .i_rst      (i_rst),
            .i_req      (idle_go && i_rd_en[k]),
            .i_addr     (rd_addr[k]),
            .i_mem_word (mem[rd_addr[k]]),
            .i_wr_hit   (wr_accept),
            .i_wr_addr  (i_wr_addr),
            .i_wr_word  (wr_merged),
            .o_data     (rd_data[k]),
            .o_valid    (o_rd_valid[k])
        );
    end

    assign o_rd_data = rd_data;
    assign o_busy    = (state_q == CLEAR);
endmodule

// File: tb/tb_reg_file_mport.sv
// Directed bench for reg_file_mport; two instances (ZERO_REG=1 and 0) share stimulus.

module tb_reg_file_mport;
    localparam int W = 32;
    localparam int A = 5;
    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   rd_en;
    logic [N*A-1:0] rd_addr;
    logic           wr_en;
    logic [A-1:0]   wr_addr;
    logic [W-1:0]   wr_data;
    logic [W/8-1:0] wr_be;
    logic           clr;
    logic [N*W-1:0] rd_data_z, rd_data_n;
    logic [N-1:0]   rd_valid_z, rd_valid_n;
    logic           busy_z, busy_n;
    int             errors = 0;
    int             checks = 0;

    always #5 clk = ~clk;

    reg_file_mport #(.WORD_SIZE(W), .ADDR_SIZE(A), .NUM_RD(N), .ZERO_REG(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data_z), .o_rd_valid(rd_valid_z), .i_wr_en(wr_en),
        .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_be(wr_be),
        .i_clr(clr), .o_busy(busy_z)
    );

    reg_file_mport #(.WORD_SIZE(W), .ADDR_SIZE(A), .NUM_RD(N), .ZERO_REG(0)) dut_nz (
        .i_clk(clk), .i_rst(rst), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data_n), .o_rd_valid(rd_valid_n), .i_wr_en(wr_en),
        .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_be(wr_be),
        .i_clr(clr), .o_busy(busy_n)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [N-1:0] en, input logic [A-1:0] a0, input logic [A-1:0] a1);
        rd_en   = en;
        rd_addr = {a1, a0};
    endtask

    task automatic wr(input logic [A-1:0] a, input logic [W-1:0] d, input logic [W/8-1:0] be);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
    endtask

    // Counts busy cycles (bounded) and flags any read-valid seen while busy.
    task automatic wait_idle(input string tag);
        int   n;
        logic vbad;
        n    = 0;
        vbad = 1'b0;
        while (busy_z && n < 100) begin
            step();
            n++;
            if ((rd_valid_z | rd_valid_n) != '0) vbad = 1'b1;
        end
        check({tag, "_len"}, 64'(n), 64'd32);
        check({tag, "_nz_busy"}, 64'(busy_n), 64'd0);
        check({tag, "_valid"}, 64'(vbad), 64'd0);
    endtask

    task automatic read_all_zero(input string tag);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rd(2'b11, i[4:0], i[4:0]);
            step();
            check({tag, "_z"}, {30'd0, rd_valid_z, rd_data_z[31:0]}, {30'd0, 2'b11, 32'd0});
            if (rd_data_z[63:32] !== 32'd0 || rd_data_n !== 64'd0 || rd_valid_n !== 2'b11) bad = 1'b1;
        end
        rd(2'b00, 5'd0, 5'd0);
        check({tag, "_other"}, 64'(bad), 64'd0);
    endtask

    initial begin
        rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; wr_be = '0; clr = 1'b0;

        // reset state
        step(); step();
        check("rst_busy", 64'(busy_z), 64'd1);
        check("rst_data", rd_data_z, 64'd0);
        check("rst_valid", 64'(rd_valid_z), 64'd0);
        rst = 1'b1;
        wait_idle("init_clr");
        read_all_zero("init_rd");

        // full write then dual-port read of same entry
        wr(5'd5, 32'hDEADBEEF, 4'hF);
        step();
        wr_en = 1'b0;
        check("wr_cycle_valid", 64'(rd_valid_z), 64'd0);
        rd(2'b11, 5'd5, 5'd5);
        step();
        check("dual_rd_data", rd_data_z, 64'hDEADBEEF_DEADBEEF);
        check("dual_rd_valid", 64'(rd_valid_z), 64'd3);

        // same-cycle partial write with bypass on port 1
        wr(5'd5, 32'h12345678, 4'b0011);
        rd(2'b10, 5'd0, 5'd5);
        step();
        wr_en = 1'b0;
        rd(2'b00, 5'd0, 5'd0);
        check("bypass_data", rd_data_z, 64'hDEAD5678_DEADBEEF);
        check("bypass_valid", 64'(rd_valid_z), 64'd2);
        step();
        check("hold_valid", 64'(rd_valid_z), 64'd0);
        check("hold_data", rd_data_z, 64'hDEAD5678_DEADBEEF);
        rd(2'b01, 5'd5, 5'd0);
        step();
        check("merged_later", 64'(rd_data_z[31:0]), 64'hDEAD5678);

        // zero register vs ordinary entry 0
        wr(5'd0, 32'hFFFFFFFF, 4'hF);
        rd(2'b10, 5'd0, 5'd0);
        step();
        wr_en = 1'b0;
        rd(2'b01, 5'd0, 5'd0);
        step();
        rd(2'b00, 5'd0, 5'd0);
        check("zero_reg_z", rd_data_z, 64'h00000000_00000000);
        check("zero_reg_n", rd_data_n, 64'hFFFFFFFF_FFFFFFFF);

        // fill 1..31, then clear with a colliding write
        for (int i = 1; i < 32; i++) begin
            wr(i[4:0], {4{i[7:0]}} ^ 32'hA5000000, 4'hF);
            step();
        end
        wr_en = 1'b0;
        rd(2'b11, 5'd7, 5'd9);
        step();
        check("fill_rd", rd_data_z, 64'hAC090909_A2070707);
        clr = 1'b1;
        wr(5'd3, 32'h11111111, 4'hF);
        rd(2'b11, 5'd3, 5'd3);
        step();
        clr = 1'b0;
        wr_en = 1'b0;
        check("clr_busy", 64'(busy_z), 64'd1);
        check("clr_valid", 64'(rd_valid_z), 64'd0);
        wait_idle("req_clr");
        check("clr_hold_data", rd_data_z, 64'hAC090909_A2070707);
        read_all_zero("post_clr");

        // reset asserted at clear index 10
        wr(5'd4, 32'hCAFEF00D, 4'hF);
        step();
        wr_en = 1'b0;
        rd(2'b11, 5'd4, 5'd4);
        step();
        rd(2'b00, 5'd0, 5'd0);
        check("pre_rst_data", rd_data_z, 64'hCAFEF00D_CAFEF00D);
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (10) step();
        rst = 1'b0;
        #1;
        check("async_rst_data", rd_data_z, 64'd0);
        check("async_rst_busy", 64'(busy_z), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_idle("rst_mid_clr");
        rd(2'b11, 5'd4, 5'd31);
        step();
        rd(2'b00, 5'd0, 5'd0);
        check("rst_clr_rd", {rd_data_z, rd_data_n} == 128'd0 ? 64'd0 : 64'd1, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
